// File: rtl/alu_cmd_driver.sv
// Command front-end for the 8-bit combinational ALU: buffers commands in a
// small FIFO, issues them through registered A/B/S operands, and returns
// each result with its opcode over a valid/ready result interface.
module alu_cmd_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic [2:0]    cmd_s,
  output logic [7:0]    A,
  output logic [7:0]    B,
  output logic [2:0]    S,
  input  logic [7:0]    Yh,
  input  logic [7:0]    Yl,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data,
  output logic [2:0]    res_op,
  output logic          busy,
  output logic [CW:0]   fifo_count
);

  localparam int unsigned NW = CW + 1;

  typedef struct packed {
    logic [2:0] s;
    logic [7:0] b;
    logic [7:0] a;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t          state;
  state_t          state_nxt;
  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            capture;
  logic            not_empty;
  logic            res_valid_nxt;
  logic [NW-1:0]   count_nxt;
  logic [15:0]     res_word;

  assign push      = cmd_valid && cmd_ready;
  assign not_empty = (fifo_count != NW'(0));
  assign head      = mem[rd_ptr];

  // Only add/sub/mul produce a meaningful high byte; mask it for the rest.
  assign res_word  = (S <= 3'b010) ? {Yh, Yl} : {8'h00, Yl};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control: pop, capture, result-valid and count.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    capture       = 1'b0;
    res_valid_nxt = res_valid;
    count_nxt     = fifo_count;
    case (state)
      IDLE: begin
        if (not_empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture       = 1'b1;
        res_valid_nxt = 1'b1;
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          if (not_empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + NW'(1);
      2'b01:   count_nxt = fifo_count - NW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'({cmd_s, cmd_b, cmd_a});
    end
  end

  // Pointers, issued operands, captured result and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      A          <= 8'h00;
      B          <= 8'h00;
      S          <= 3'b000;
      res_valid  <= 1'b0;
      res_data   <= 16'h0000;
      res_op     <= 3'b000;
      fifo_count <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (pop) begin
        A      <= head.a;
        B      <= head.b;
        S      <= head.s;
        rd_ptr <= rd_ptr + CW'(1);
      end
      if (capture) begin
        res_data <= res_word;
        res_op   <= S;
      end
      res_valid  <= res_valid_nxt;
      fifo_count <= count_nxt;
      // Ready follows the post-edge count, so a pop while full does not bypass.
      cmd_ready  <= (count_nxt != NW'(DEPTH));
      busy       <= (state_nxt != IDLE) || (count_nxt != NW'(0));
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural ALU model.
module tb_alu_cmd_driver;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_s;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  S;
  logic [7:0]  yh;
  logic [7:0]  yl;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_op;
  logic        busy;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [18:0] exp_q [$];
  logic [18:0] obs_q [$];
  int          obs_cyc [$];

  alu_cmd_driver #(.DEPTH(4), .CW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
    .A(A), .B(B), .S(S), .Yh(yh), .Yl(yl),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model; high byte is junk for single-byte ops to expose missing masking.
  always_comb begin
    yh = 8'hAA;
    yl = 8'h00;
    case (S)
      3'd0: {yh, yl} = 16'(A) + 16'(B);
      3'd1: {yh, yl} = 16'(A) - 16'(B);
      3'd2: {yh, yl} = 16'(A) * 16'(B);
      3'd3: yl = A + 8'd1;
      3'd4: yl = A << B;
      3'd5: yl = A & B;
      3'd6: yl = A | B;
      default: yl = A ^ B;
    endcase
  end

  function automatic logic [18:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
    logic [15:0] r;
    logic [7:0]  t;
    t = 8'h00;
    case (s)
      3'd0: r = 16'(a) + 16'(b);
      3'd1: r = 16'(a) - 16'(b);
      3'd2: r = 16'(a) * 16'(b);
      default: begin
        case (s)
          3'd3: t = a + 8'd1;
          3'd4: t = a << b;
          3'd5: t = a & b;
          3'd6: t = a | b;
          default: t = a ^ b;
        endcase
        r = {8'h00, t};
      end
    endcase
    return {s, r};
  endfunction

  // Record accepted commands as expectations and handshaken results as observations.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (cmd_valid && cmd_ready) exp_q.push_back(ref_res(cmd_a, cmd_b, cmd_s));
      if (res_valid && res_ready) begin
        obs_q.push_back({res_op, res_data});
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    int cnt;
    cnt = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_s = s;
    while (!cmd_ready && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cnt >= 300) begin
      errors++;
      $display("FAIL send_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
    end
  endtask

  task automatic wait_results(input int n, output bit ok);
    int cnt;
    cnt = 0;
    while (obs_q.size() < n && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 8'h00;
    cmd_b = 8'h00;
    cmd_s = 3'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({A, B, S} !== 19'h0) begin
      errors++; $display("FAIL reset_abs: A=%0h B=%0h S=%0h, required 0", A, B, S);
    end
    checks++;
    if ({res_valid, res_data, res_op} !== 20'h0) begin
      errors++; $display("FAIL reset_res: v=%0b d=%0h op=%0h, required 0", res_valid, res_data, res_op);
    end
    checks++;
    if ({cmd_ready, busy, fifo_count} !== 5'b10_000) begin
      errors++; $display("FAIL reset_flags: ready=%0b busy=%0b cnt=%0d, required 1 0 0",
                         cmd_ready, busy, fifo_count);
    end
  endtask

  task automatic test_single_add;
    bit ok;
    logic [18:0] o, e;
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_a = 8'd200;
    cmd_b = 8'd100;
    cmd_s = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL add_accept: cnt=%0d busy=%0b, required 1 1", fifo_count, busy);
    end
    @(negedge clk);
    checks++;
    if ({A, B, S} !== {8'd200, 8'd100, 3'd0} || res_valid !== 1'b0) begin
      errors++; $display("FAIL add_issue: A=%0d B=%0d S=%0d v=%0b, required 200 100 0 0",
                         A, B, S, res_valid);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h012C || res_op !== 3'd0) begin
      errors++; $display("FAIL add_result: v=%0b d=%0h op=%0d, required 1 012c 0",
                         res_valid, res_data, res_op);
    end
    wait_results(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL add_timeout: got %0d results, required 1", obs_q.size());
    end
    if (ok && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL add_sb: got %0h, required %0h", o, e);
      end
    end
  endtask

  task automatic test_ops;
    bit ok;
    logic [18:0] o, e;
    logic [18:0] lit [3];
    lit[0] = {3'd1, 16'hFFFE};
    lit[1] = {3'd2, 16'hFE01};
    lit[2] = {3'd4, 16'h0002};
    res_ready = 1'b1;
    send(8'd3, 8'd5, 3'd1);
    send(8'd255, 8'd255, 3'd2);
    send(8'h81, 8'd1, 3'd4);
    send(8'hFF, 8'h00, 3'd3);
    send(8'hF0, 8'h3C, 3'd5);
    send(8'hF0, 8'h3C, 3'd6);
    send(8'hF0, 8'h3C, 3'd7);
    wait_results(7, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ops_timeout: got %0d results, required 7", obs_q.size());
    end
    for (int i = 0; i < 7 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL ops_sb[%0d]: got %0h, required %0h", i, o, e);
      end
      if (i < 3) begin
        checks++;
        if (o !== lit[i]) begin
          errors++; $display("FAIL ops_lit[%0d]: got %0h, required %0h", i, o, lit[i]);
        end
      end
    end
  endtask

  task automatic test_fill_hold;
    bit ok;
    logic [18:0] o, e;
    int c [5];
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(10 + i), 8'(3 * i), 3'(i));
    checks++;
    if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL fill_full: ready=%0b cnt=%0d, required 0 4", cmd_ready, fifo_count);
    end
    cmd_valid = 1'b1;
    cmd_a = 8'h77;
    cmd_b = 8'h11;
    cmd_s = 3'd0;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || exp_q.size() != 5) begin
      errors++; $display("FAIL fill_reject: cnt=%0d accepted=%0d, required 4 5", fifo_count, exp_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (res_valid !== 1'b1 || {res_op, res_data} !== exp_q[0]) begin
        errors++; $display("FAIL hold_stable[%0d]: v=%0b got %0h, required 1 %0h",
                           i, res_valid, {res_op, res_data}, exp_q[0]);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || fifo_count !== 3'd3) begin
      errors++; $display("FAIL pulse_one: consumed=%0d cnt=%0d, required 1 3", obs_q.size(), fifo_count);
    end
    res_ready = 1'b1;
    wait_results(5, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL fill_timeout: got %0d results, required 5", obs_q.size());
    end
    for (int i = 0; i < 5 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      c[i] = obs_cyc.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL fill_sb[%0d]: got %0h, required %0h", i, o, e);
      end
      if (i >= 2) begin
        checks++;
        if (c[i] - c[i-1] != 2) begin
          errors++; $display("FAIL fill_spacing[%0d]: got %0d cycles, required 2", i, c[i] - c[i-1]);
        end
      end
    end
  endtask

  task automatic test_simul_push_pop;
    bit ok;
    logic [18:0] o, e;
    res_ready = 1'b0;
    send(8'd1, 8'd2, 3'd0);
    send(8'd9, 8'd4, 3'd1);
    send(8'd7, 8'd6, 3'd2);
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd2 || res_valid !== 1'b1) begin
      errors++; $display("FAIL simul_pre: cnt=%0d v=%0b, required 2 1", fifo_count, res_valid);
    end
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_a = 8'h5A;
    cmd_b = 8'h0F;
    cmd_s = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || res_valid !== 1'b0) begin
      errors++; $display("FAIL simul_count: cnt=%0d v=%0b, required 2 0", fifo_count, res_valid);
    end
    res_ready = 1'b1;
    wait_results(4, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL simul_timeout: got %0d results, required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL simul_sb[%0d]: got %0h, required %0h", i, o, e);
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [18:0] o, e;
    res_ready = 1'b1;
    for (int i = 0; i < 14; i++) send(8'($urandom), 8'($urandom_range(0, 9)), 3'($urandom));
    wait_results(14, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wrap_timeout: got %0d results, required 14", obs_q.size());
    end
    for (int i = 0; i < 14 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL wrap_sb[%0d]: got %0h, required %0h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [18:0] o, e;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(40 + i), 8'(i), 3'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd3 || res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: cnt=%0d v=%0b busy=%0b, required 3 0 1",
                         fifo_count, res_valid, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || fifo_count !== 3'd0 || {A, B, S} !== 19'h0 || busy !== 1'b0
        || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: v=%0b cnt=%0d A=%0h B=%0h S=%0h busy=%0b ready=%0b",
                         res_valid, fifo_count, A, B, S, busy, cmd_ready);
    end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 5) begin
      errors++; $display("FAIL rstmid_consumed: got %0d/%0d, required 1/5", obs_q.size(), exp_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      void'(obs_cyc.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL rstmid_sb: got %0h, required %0h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    res_ready = 1'b1;
    send(8'd250, 8'd10, 3'd0);
    wait_results(1, ok);
    checks++;
    if (!ok || obs_q.size() == 0 || obs_q[0] !== {3'd0, 16'h0104}) begin
      errors++; $display("FAIL rstmid_after: ok=%0b got %0h, required 0104", ok,
                         (obs_q.size() > 0) ? obs_q[0] : 19'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops();
    test_fill_hold();
    test_simul_push_pop();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
